// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and width helper for the serial arithmetic datapaths
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - bi cell with borrow-out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, with start/busy/done handshake
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] sa, sb, wd, wd_next;
  logic [CW-1:0] cnt;
  logic br, a_msb, b_msb, d, bo;
  full_subtractor u_fs (.x(sa[0]), .y(sb[0]), .bi(br), .d(d), .bo(bo));
  assign wd_next = {d, wd[WIDTH-1:1]};
  assign busy = state == RUN;
  assign done = state == DONE;
  // operand MSBs are kept aside because sa/sb are consumed by the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      wd <= '0;
      br <= 1'b0;
      cnt <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      wd <= wd_next;
      br <= bo;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        diff <= wd_next;
        bout <= bo;
        ovf <= (a_msb ^ b_msb) & (d ^ a_msb);
        state <= DONE;
      end
    end else if (start) begin
      sa <= a;
      sb <= b;
      br <= bin;
      cnt <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      state <= RUN;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of the 4-bit serial subtractor
module tb_serial_subtractor;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
  logic [3:0] a = '0, b = '0, diff;
  logic busy, done, bout, ovf;
  int tests = 0, fails = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] av, input logic [3:0] bv, input logic bi);
    a = av;
    b = bv;
    bin = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic op(input string tag, input logic [3:0] av, input logic [3:0] bv, input logic bi,
                    input logic [3:0] ed, input logic eb, input logic eo);
    launch(av, bv, bi);
    wait_done(tag, 4);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int sv, dones, lat;
    logic [3:0] ed;
    logic eb, eo;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      bin = 1'($urandom);
    end
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    launch(4'd9, 4'd3, 1'b0);
    lat = 0;
    while (busy === 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("basic_busy_cycles", lat, 4);
    check("basic_done", done, 1);
    check("basic_diff", diff, 4'd6);
    check("basic_bout", bout, 0);
    check("basic_ovf", ovf, 1);
    @(negedge clk);
    check("basic_done_pulse", done, 0);
    check("basic_idle_busy", busy, 0);

    op("under", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
    @(negedge clk);
    op("zero_bin", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    op("b2b", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
    @(negedge clk);

    launch(4'd5, 4'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 4'd15;
    b = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 1);
    check("ignore_diff", diff, 4'd3);
    check("ignore_bout", bout, 0);
    check("ignore_ovf", ovf, 0);
    @(negedge clk);

    launch(4'd7, 4'd3, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_diff", diff, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    op("fresh", 4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 512; i++) begin
      logic [3:0] av, bv;
      logic bi;
      av = 4'(i >> 5);
      bv = 4'(i >> 1);
      bi = 1'(i);
      ed = av - bv - 4'(bi);
      eb = int'(av) < int'(bv) + int'(bi);
      sv = int'($signed(av)) - int'($signed(bv)) - int'(bi);
      eo = sv < -8 || sv > 7;
      op($sformatf("ex_%0d_%0d_%0d", av, bv, bi), av, bv, bi, ed, eb, eo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
